atomic_alu_controller: RTL and testbench

Parametrised successor to the atomic ALU controller. It owns a NUM_REGS x DATA_W register file, decodes 3-address commands, and drives an external combinational ALU. Results and flags are written back, and a compare-and-swap (CAS) executes as an uninterruptible multi-cycle sequence. It sits between the host command interface and the ALU and replaces file-based register init with a host load port.

---
 rtl/atomic_alu_pkg.sv | 44 ++++
 rtl/atomic_alu_controller_if.sv | 48 ++++
 rtl/atomic_regfile.sv | 66 ++++++
 rtl/atomic_alu_controller.sv | 163 ++++++++++++++++
 tb/tb_atomic_alu_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atomic_alu_pkg.sv
// Shared types for the atomic ALU controller: opcodes, FSM states,
// the decoded command view and the response flag bit positions.
package atomic_alu_pkg;

   // Opcode encoding is fixed at 3 bits; the controller's OP_W defaults to this.
   localparam int OPCODE_W = 3;

   // Decoded addresses are zero-extended to this width so one command type
   // serves every NUM_REGS up to 256.
   localparam int ADDR_W_MAX = 8;

   typedef enum logic [OPCODE_W-1:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_AND    = 3'b010,
      OP_OR     = 3'b011,
      OP_XOR    = 3'b100,
      OP_SLT    = 3'b101,
      OP_PASS_A = 3'b110,
      OP_CAS    = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_WB,
      ST_CAS_CMP,
      ST_CAS_WB
   } state_e;

   typedef struct packed {
      op_e                   op;
      logic [ADDR_W_MAX-1:0] a1;
      logic [ADDR_W_MAX-1:0] a2;
      logic [ADDR_W_MAX-1:0] a3;
   } cmd_t;

   // Bit positions inside resp_flags = {O,C,Z,N}.
   localparam int FLAG_O = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/atomic_alu_controller_if.sv
// Host command/response, external ALU and host register-load signals of the
// atomic ALU controller. master = host/ALU side, slave = controller side.
interface atomic_alu_controller_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter int OP_W     = 3
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int CMD_W  = OP_W + 3*ADDR_W;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [CMD_W-1:0]  cmd;

   logic [OP_W-1:0]   alu_op_code;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] data_b;
   logic [DATA_W-1:0] alu_y;
   logic              alu_o;
   logic              alu_c;
   logic              alu_z;
   logic              alu_n;

   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [3:0]        resp_flags;

   logic              host_we;
   logic [ADDR_W-1:0] host_waddr;
   logic [DATA_W-1:0] host_wdata;
   logic [ADDR_W-1:0] host_raddr;
   logic [DATA_W-1:0] host_rdata;

   modport master (
      output cmd_valid, cmd, alu_y, alu_o, alu_c, alu_z, alu_n,
             host_we, host_waddr, host_wdata, host_raddr,
      input  cmd_ready, alu_op_code, data_a, data_b,
             resp_valid, resp_data, resp_flags, host_rdata
   );

   modport slave (
      input  cmd_valid, cmd, alu_y, alu_o, alu_c, alu_z, alu_n,
             host_we, host_waddr, host_wdata, host_raddr,
      output cmd_ready, alu_op_code, data_a, data_b,
             resp_valid, resp_data, resp_flags, host_rdata
   );

endinterface

// File: rtl/atomic_regfile.sv
// NUM_REGS x DATA_W register file: two operand read ports, one host read
// port, a controller write port and a host write port (controller wins).
// Addresses at or above NUM_REGS read as zero and are never written.
module atomic_regfile
   import atomic_alu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W_MAX-1:0] rd_a_addr_i,
   input  logic [ADDR_W_MAX-1:0] rd_b_addr_i,
   input  logic [ADDR_W_MAX-1:0] host_raddr_i,
   output logic [DATA_W-1:0]     rd_a_data_o,
   output logic [DATA_W-1:0]     rd_b_data_o,
   output logic [DATA_W-1:0]     host_rdata_o,
   input  logic                  ctrl_we_i,
   input  logic [ADDR_W_MAX-1:0] ctrl_waddr_i,
   input  logic [DATA_W-1:0]     ctrl_wdata_i,
   input  logic                  host_we_i,
   input  logic [ADDR_W_MAX-1:0] host_waddr_i,
   input  logic [DATA_W-1:0]     host_wdata_i
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   // Address match by comparison so non-power-of-2 sizes read zero beyond the end.
   function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W_MAX-1:0] addr);
      logic [DATA_W-1:0] val;
      val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == ADDR_W_MAX'(i)) val = regs_q[i];
      end
      return val;
   endfunction

   // Combinational read ports.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      rd_a_data_o  = '0;
      rd_b_data_o  = '0;
      host_rdata_o = '0;
      rd_a_data_o  = read_reg(rd_a_addr_i);
      rd_b_data_o  = read_reg(rd_b_addr_i);
      host_rdata_o = read_reg(host_raddr_i);
   end

   // Register storage: clear on reset, controller write has priority over host.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the storage array is cleared deliberately; reset must zero every register.
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (ctrl_we_i && ctrl_waddr_i == ADDR_W_MAX'(i)) begin
               regs_q[i] <= ctrl_wdata_i;
            end else if (host_we_i && host_waddr_i == ADDR_W_MAX'(i)) begin
               regs_q[i] <= host_wdata_i;
            end
         end
      end
   end

endmodule

// File: rtl/atomic_alu_controller.sv
// Decodes 3-address commands, drives the external ALU from registered
// operands and writes results back; CAS runs as an uninterruptible
// compare-then-write sequence during which host writes are locked out.
module atomic_alu_controller
   import atomic_alu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter int OP_W     = OPCODE_W
) (
   input logic                     clk,
   input logic                     rst,
   atomic_alu_controller_if.slave  bus
);

   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int CMD_W  = OP_W + 3*ADDR_W;
   localparam int AW     = ADDR_W_MAX;

   state_e            state_q;
   logic [AW-1:0]     a1_q, a2_q, a3_q;
   logic [OP_W-1:0]   alu_op_q;
   logic [DATA_W-1:0] data_a_q, data_b_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_data_q;
   logic [3:0]        resp_flags_q;

   cmd_t              cmd_in;
   logic [3:0]        alu_flags;
   logic [AW-1:0]     rd_a_addr, rd_b_addr;
   logic [DATA_W-1:0] rd_a_data, rd_b_data;
   logic              ctrl_we;
   logic [AW-1:0]     ctrl_waddr;
   logic [DATA_W-1:0] ctrl_wdata;
   logic              host_we_ok;

   // Split the incoming command word {op, a1, a2, a3} into its fields.
   always_comb begin
      cmd_in    = '0;
      cmd_in.op = op_e'(bus.cmd[CMD_W-1 -: OP_W]);
      cmd_in.a1 = AW'(bus.cmd[3*ADDR_W-1 -: ADDR_W]);
      cmd_in.a2 = AW'(bus.cmd[2*ADDR_W-1 -: ADDR_W]);
      cmd_in.a3 = AW'(bus.cmd[ADDR_W-1:0]);
   end

   // Pack ALU flags into the {O,C,Z,N} response layout.
   always_comb begin
      alu_flags         = '0;
      alu_flags[FLAG_O] = bus.alu_o;
      alu_flags[FLAG_C] = bus.alu_c;
      alu_flags[FLAG_Z] = bus.alu_z;
      alu_flags[FLAG_N] = bus.alu_n;
   end

   // Read addressing: operands at accept; port A fetches reg[a2] for a CAS swap.
   always_comb begin
      rd_a_addr = cmd_in.a1;
      if (state_q == ST_CAS_CMP) rd_a_addr = a2_q;
      rd_b_addr = (cmd_in.op == OP_CAS) ? cmd_in.a3 : cmd_in.a2;
   end

   // Writeback select: ALU result to a3, or CAS swap to a1 / current value to a3.
   always_comb begin
      ctrl_we    = 1'b0;
      ctrl_waddr = a3_q;
      ctrl_wdata = bus.alu_y;
      case (state_q)
         ST_EXEC: ctrl_we = 1'b1;
         ST_CAS_CMP: begin
            ctrl_we = 1'b1;
            if (bus.alu_z) begin
               ctrl_waddr = a1_q;
               ctrl_wdata = rd_a_data;
            end else begin
               ctrl_wdata = data_a_q;
            end
         end
         default: ctrl_we = 1'b0;
      endcase
   end

   // Host writes only land while idle, which keeps CAS atomic.
   assign host_we_ok = bus.host_we && (state_q == ST_IDLE);

   atomic_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk          (clk),
      .rst          (rst),
      .rd_a_addr_i  (rd_a_addr),
      .rd_b_addr_i  (rd_b_addr),
      .host_raddr_i (AW'(bus.host_raddr)),
      .rd_a_data_o  (rd_a_data),
      .rd_b_data_o  (rd_b_data),
      .host_rdata_o (bus.host_rdata),
      .ctrl_we_i    (ctrl_we),
      .ctrl_waddr_i (ctrl_waddr),
      .ctrl_wdata_i (ctrl_wdata),
      .host_we_i    (host_we_ok),
      .host_waddr_i (AW'(bus.host_waddr)),
      .host_wdata_i (bus.host_wdata)
   );

   // Command FSM with registered ALU operands and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         a1_q         <= '0;
         a2_q         <= '0;
         a3_q         <= '0;
         alu_op_q     <= '0;
         data_a_q     <= '0;
         data_b_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_flags_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  a1_q     <= cmd_in.a1;
                  a2_q     <= cmd_in.a2;
                  a3_q     <= cmd_in.a3;
                  data_a_q <= rd_a_data;
                  data_b_q <= rd_b_data;
                  if (cmd_in.op == OP_CAS) begin
                     alu_op_q <= OP_W'(OP_SUB);
                     state_q  <= ST_CAS_CMP;
                  end else begin
                     alu_op_q <= OP_W'(cmd_in.op);
                     state_q  <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               resp_data_q  <= bus.alu_y;
               resp_flags_q <= alu_flags;
               resp_valid_q <= 1'b1;
               state_q      <= ST_WB;
            end
            ST_CAS_CMP: begin
               resp_data_q  <= bus.alu_z ? DATA_W'(1) : '0;
               resp_flags_q <= alu_flags;
               resp_valid_q <= 1'b1;
               state_q      <= ST_CAS_WB;
            end
            ST_WB, ST_CAS_WB: state_q <= ST_IDLE;
            default:          state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.alu_op_code = alu_op_q;
   assign bus.data_a      = data_a_q;
   assign bus.data_b      = data_b_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_flags  = resp_flags_q;

endmodule

// File: tb/tb_atomic_alu_controller.sv
// Bench for atomic_alu_controller: a default 8-register instance exercised
// with directed and random commands against a register-array model, plus a
// 6-register instance for out-of-range addressing.
module tb_atomic_alu_controller;

   localparam int DW  = 32;
   localparam int NR  = 8;
   localparam int NR1 = 6;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   atomic_alu_controller_if #(.DATA_W(DW), .NUM_REGS(NR),  .OP_W(3)) bus0 ();
   atomic_alu_controller_if #(.DATA_W(DW), .NUM_REGS(NR1), .OP_W(3)) bus1 ();

   atomic_alu_controller #(.DATA_W(DW), .NUM_REGS(NR),  .OP_W(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   atomic_alu_controller #(.DATA_W(DW), .NUM_REGS(NR1), .OP_W(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // External combinational ALU: returns {y, O, C, Z, N}.
   function automatic logic [DW+3:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0]   wide;
      logic [DW-1:0] y;
      logic          o, c;
      wide = '0; y = '0; o = 1'b0; c = 1'b0;
      case (op)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            y = wide[DW-1:0];
            c = wide[DW];
            o = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
         end
         3'd1: begin
            y = a - b;
            c = (a < b);
            o = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
         end
         3'd2: y = a & b;
         3'd3: y = a | b;
         3'd4: y = a ^ b;
         3'd5: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
         3'd6: y = a;
         default: y = '0;
      endcase
      return {y, o, c, (y == '0), y[DW-1]};
   endfunction

   always_comb {bus0.alu_y, bus0.alu_o, bus0.alu_c, bus0.alu_z, bus0.alu_n} =
      alu_f(bus0.alu_op_code, bus0.data_a, bus0.data_b);
   always_comb {bus1.alu_y, bus1.alu_o, bus1.alu_c, bus1.alu_z, bus1.alu_n} =
      alu_f(bus1.alu_op_code, bus1.data_a, bus1.data_b);

   logic [DW-1:0] mdl [NR];
   int checks = 0;
   int errors = 0;
   int last_wait;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input int addr, input logic [DW-1:0] data);
      bus0.host_we    = 1'b1;
      bus0.host_waddr = 3'(addr);
      bus0.host_wdata = data;
      step();
      bus0.host_we = 1'b0;
      mdl[addr] = data;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++) begin
         bus0.host_raddr = 3'(i);
         #1;
         check($sformatf("%s r%0d", tag, i), bus0.host_rdata, mdl[i]);
      end
   endtask

   // Issue one command on dut0, predict its outcome from the register model
   // and check operands, timing, response and final register contents.
   task automatic run_cmd(input logic [2:0] op, input int a1, input int a2, input int a3,
                          input bit inj, input int inj_addr, input logic [DW-1:0] inj_data,
                          input bit keep);
      logic [DW-1:0] va, vb, vc, exp_y, exp_db;
      logic [DW+3:0] r;
      logic [3:0]    exp_f;
      logic [2:0]    exp_op;
      int            n;
      string         t;
      t  = $sformatf("op%0d(%0d,%0d,%0d)", op, a1, a2, a3);
      va = mdl[a1]; vb = mdl[a2]; vc = mdl[a3];
      if (op == 3'd7) begin
         r      = alu_f(3'd1, va, vc);
         exp_f  = r[3:0];
         exp_op = 3'd1;
         exp_db = vc;
         if (va == vc) begin
            exp_y   = 1;
            mdl[a1] = vb;
         end else begin
            exp_y   = 0;
            mdl[a3] = va;
         end
      end else begin
         r       = alu_f(op, va, vb);
         exp_y   = r[DW+3:4];
         exp_f   = r[3:0];
         exp_op  = op;
         exp_db  = vb;
         mdl[a3] = exp_y;
      end
      bus0.cmd       = {op, 3'(a1), 3'(a2), 3'(a3)};
      bus0.cmd_valid = 1'b1;
      n = 0;
      while (!bus0.cmd_ready && n < 10) begin
         step();
         n++;
      end
      last_wait = n;
      check({t, " ready"}, bus0.cmd_ready, 1);
      step();
      bus0.cmd_valid = keep;
      if (inj) begin
         bus0.host_we    = 1'b1;
         bus0.host_waddr = 3'(inj_addr);
         bus0.host_wdata = inj_data;
      end
      check({t, " c1 resp_valid"}, bus0.resp_valid, 0);
      check({t, " c1 cmd_ready"}, bus0.cmd_ready, 0);
      check({t, " alu_op"}, bus0.alu_op_code, exp_op);
      check({t, " data_a"}, bus0.data_a, va);
      check({t, " data_b"}, bus0.data_b, exp_db);
      step();
      check({t, " c2 resp_valid"}, bus0.resp_valid, 1);
      check({t, " c2 cmd_ready"}, bus0.cmd_ready, 0);
      check({t, " resp_data"}, bus0.resp_data, exp_y);
      check({t, " resp_flags"}, bus0.resp_flags, exp_f);
      step();
      bus0.host_we = 1'b0;
      check({t, " c3 resp_valid"}, bus0.resp_valid, 0);
      check({t, " c3 cmd_ready"}, bus0.cmd_ready, 1);
      check_regs(t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int nw, n;
      rst = 1'b1;
      bus0.cmd_valid = 1'b0; bus0.cmd = '0; bus0.host_we = 1'b0;
      bus0.host_waddr = '0; bus0.host_wdata = '0; bus0.host_raddr = '0;
      bus1.cmd_valid = 1'b0; bus1.cmd = '0; bus1.host_we = 1'b0;
      bus1.host_waddr = '0; bus1.host_wdata = '0; bus1.host_raddr = '0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      repeat (2) step();
      rst = 1'b0;

      check("reset cmd_ready", bus0.cmd_ready, 1);
      check("reset resp_valid", bus0.resp_valid, 0);
      check("reset resp_data", bus0.resp_data, 0);
      check("reset resp_flags", bus0.resp_flags, 0);
      check("reset data_a", bus0.data_a, 0);
      check("reset alu_op", bus0.alu_op_code, 0);
      check_regs("reset");

      // ADD r4 = r1 + r2
      host_write(1, 5);
      host_write(2, 3);
      run_cmd(3'd0, 1, 2, 4, 0, 0, 0, 0);
      check("add result", bus0.resp_data, 8);
      check("add Z", bus0.resp_flags[1], 0);

      // SUB r5 = r1 - r1
      run_cmd(3'd1, 1, 1, 5, 0, 0, 0, 0);
      check("sub result", bus0.resp_data, 0);
      check("sub Z", bus0.resp_flags[1], 1);

      // CAS match
      host_write(1, 7);
      host_write(2, 9);
      host_write(3, 7);
      run_cmd(3'd7, 1, 2, 3, 0, 0, 0, 0);
      check("cas match result", bus0.resp_data, 1);

      // CAS miss with a host write to r1 attempted mid-sequence
      host_write(1, 7);
      host_write(3, 6);
      run_cmd(3'd7, 1, 2, 3, 1, 1, 32'hdead_beef, 0);
      check("cas miss result", bus0.resp_data, 0);

      // CAS with a1 == a3 always matches
      host_write(4, 32'h1234);
      run_cmd(3'd7, 4, 2, 4, 0, 0, 0, 0);
      check("cas self Z", bus0.resp_flags[1], 1);

      // Back-to-back: cmd_valid held high across two commands
      run_cmd(3'd0, 1, 2, 6, 0, 0, 0, 1);
      run_cmd(3'd4, 6, 1, 0, 0, 0, 0, 0);
      check("b2b second accept wait", last_wait, 0);

      // Random commands against the model
      for (int k = 0; k < 40; k++) begin
         nw = $urandom_range(0, 2);
         for (int j = 0; j < nw; j++) begin
            host_write($urandom_range(0, NR-1),
                       ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 3)));
         end
         run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, NR-1), $urandom_range(0, NR-1),
                 $urandom_range(0, NR-1), 0, 0, 0, 0);
      end

      // Reset asserted during EXEC discards the writeback and clears everything
      host_write(0, 32'h11);
      host_write(5, 32'h22);
      bus0.cmd = {3'd0, 3'd0, 3'd5, 3'd7};
      bus0.cmd_valid = 1'b1;
      n = 0;
      while (!bus0.cmd_ready && n < 10) begin
         step();
         n++;
      end
      check("rst test ready", bus0.cmd_ready, 1);
      step();
      bus0.cmd_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      check("mid rst cmd_ready", bus0.cmd_ready, 1);
      check("mid rst resp_valid", bus0.resp_valid, 0);
      check("mid rst data_a", bus0.data_a, 0);
      check("mid rst data_b", bus0.data_b, 0);
      check("mid rst alu_op", bus0.alu_op_code, 0);
      check("mid rst resp_data", bus0.resp_data, 0);
      check("mid rst resp_flags", bus0.resp_flags, 0);
      step();
      check("mid rst late resp_valid", bus0.resp_valid, 0);
      check_regs("mid rst");

      // 6-register instance: out-of-range writeback and reads
      bus1.host_we = 1'b1;
      bus1.host_waddr = 3'd1; bus1.host_wdata = 10;
      step();
      bus1.host_waddr = 3'd2; bus1.host_wdata = 20;
      step();
      bus1.host_waddr = 3'd7; bus1.host_wdata = 99;
      step();
      bus1.host_we = 1'b0;
      bus1.cmd = {3'd0, 3'd1, 3'd2, 3'd7};
      bus1.cmd_valid = 1'b1;
      n = 0;
      while (!bus1.cmd_ready && n < 10) begin
         step();
         n++;
      end
      check("n6 ready", bus1.cmd_ready, 1);
      step();
      bus1.cmd_valid = 1'b0;
      check("n6 c1 resp_valid", bus1.resp_valid, 0);
      step();
      check("n6 resp_valid", bus1.resp_valid, 1);
      check("n6 resp_data", bus1.resp_data, 30);
      step();
      for (int i = 0; i < 8; i++) begin
         bus1.host_raddr = 3'(i);
         #1;
         check($sformatf("n6 r%0d", i), bus1.host_rdata, (i == 1) ? 10 : (i == 2) ? 20 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
